mdll_div_sequencer: RTL and testbench

Frame sequencer for the FMDLL injection path. It runs on the DLL output clock and generates the N/M divider counts, the DIV_N and DIV_M strobes, and the 2-bit injection select. The select chooses between reference injection, fractional re-injection and free-run for the delay-line input mux. It also latches divider configuration safely at frame boundaries, so N/M can be changed without corrupting a frame in progress.

---
 rtl/mdll_div_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_mdll_div_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mdll_div_sequencer.sv
// mdll_div_sequencer: frame sequencer for the FMDLL injection path.
// Runs on the DLL output clock. Generates the N/M divider counts, the DIV_N and
// DIV_M strobes and the 2-bit injection select (00 reference, 10 fractional,
// 01 free-run). Divider ratios are captured into shadow registers only at frame
// boundaries, so a frame in progress always completes with the old ratios.
// The internal counter state runs one cycle ahead of the outputs. Every output is
// a flop decoded from that registered state.
// Optional feature: define FRAME_CNT_EN to build the saturating completed-frame
// counter. When it is undefined, frame_cnt is tied to zero.
module mdll_div_sequencer (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] N,
    input  logic [1:0] M,
    output logic [3:0] N_counter,
    output logic [1:0] M_counter,
    output logic       DIV_N,
    output logic       DIV_M,
    output logic [1:0] Sel,
    output logic       frame_done,
    output logic       cfg_err,
    output logic [7:0] frame_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [3:0] n_cfg_q, n_cfg_d, n_cnt_q, n_cnt_d;
    logic [1:0] m_cfg_q, m_cfg_d, m_cnt_q, m_cnt_d;
    logic       err_flag_q, err_flag_d;

    logic [3:0] n_counter_q, n_counter_d;
    logic [1:0] m_counter_q, m_counter_d;
    logic       div_n_q, div_n_d, div_m_q, div_m_d;
    logic [1:0] sel_q, sel_d;
    logic       frame_done_q, frame_done_d;
    logic       cfg_err_q, cfg_err_d;

    logic       cfg_ok, end_n, end_m, active;
    logic [3:0] n_adv;
    logic [1:0] m_adv;

    assign cfg_ok = (N >= 4'd2) && (M != 2'd0);
    assign end_n  = (n_cnt_q == n_cfg_q);
    assign end_m  = end_n && (m_cnt_q == m_cfg_q);
    assign active = (state_q != IDLE);
    assign n_adv  = end_n ? 4'd1 : n_cnt_q + 4'd1;
    assign m_adv  = end_n ? ((m_cnt_q == m_cfg_q) ? 2'd1 : m_cnt_q + 2'd1) : m_cnt_q;

    // Sequencer next state: start/stop decisions and shadow reloads at frame ends
    always_comb begin
        state_d    = state_q;
        n_cfg_d    = n_cfg_q;
        m_cfg_d    = m_cfg_q;
        n_cnt_d    = n_cnt_q;
        m_cnt_d    = m_cnt_q;
        err_flag_d = err_flag_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (cfg_ok) begin
                        n_cfg_d    = N;
                        m_cfg_d    = M;
                        err_flag_d = 1'b0;
                        n_cnt_d    = 4'd1;
                        m_cnt_d    = 2'd1;
                        state_d    = RUN;
                    end else begin
                        err_flag_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (end_m) begin
                    if (en && cfg_ok) begin
                        n_cfg_d = N;
                        m_cfg_d = M;
                        n_cnt_d = 4'd1;
                        m_cnt_d = 2'd1;
                    end else begin
                        if (en) err_flag_d = 1'b1;
                        n_cnt_d = 4'd0;
                        m_cnt_d = 2'd0;
                        state_d = IDLE;
                    end
                end else begin
                    n_cnt_d = n_adv;
                    m_cnt_d = m_adv;
                    if (!en) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // en returning here is ignored; a restart is taken from IDLE
                if (end_m) begin
                    n_cnt_d = 4'd0;
                    m_cnt_d = 2'd0;
                    state_d = IDLE;
                end else begin
                    n_cnt_d = n_adv;
                    m_cnt_d = m_adv;
                end
            end
            default: begin
                n_cnt_d = 4'd0;
                m_cnt_d = 2'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the registered counter state
    always_comb begin
        n_counter_d  = n_cnt_q;
        m_counter_d  = m_cnt_q;
        div_n_d      = active && end_n;
        div_m_d      = active && end_m;
        frame_done_d = active && end_m;
        cfg_err_d    = err_flag_q;
        if (n_cnt_q == 4'd1 && m_cnt_q == 2'd1)
            sel_d = 2'b00;
        else if (active && end_n && (m_cnt_q != m_cfg_q))
            sel_d = 2'b10;
        else
            sel_d = 2'b01;
    end

    // State, shadow and output registers
    always_ff @(posedge clk_out) begin
        if (rst) begin
            state_q      <= IDLE;
            n_cfg_q      <= 4'd2;
            m_cfg_q      <= 2'd1;
            n_cnt_q      <= 4'd0;
            m_cnt_q      <= 2'd0;
            err_flag_q   <= 1'b0;
            n_counter_q  <= 4'd0;
            m_counter_q  <= 2'd0;
            div_n_q      <= 1'b0;
            div_m_q      <= 1'b0;
            sel_q        <= 2'b01;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_cfg_q      <= n_cfg_d;
            m_cfg_q      <= m_cfg_d;
            n_cnt_q      <= n_cnt_d;
            m_cnt_q      <= m_cnt_d;
            err_flag_q   <= err_flag_d;
            n_counter_q  <= n_counter_d;
            m_counter_q  <= m_counter_d;
            div_n_q      <= div_n_d;
            div_m_q      <= div_m_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign N_counter  = n_counter_q;
    assign M_counter  = m_counter_q;
    assign DIV_N      = div_n_q;
    assign DIV_M      = div_m_q;
    assign Sel        = sel_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;

`ifdef FRAME_CNT_EN
    logic [7:0] fcnt_q, fcnt_d, frame_cnt_q, frame_cnt_d;
    logic       frame_end;

    assign frame_end = active && end_m;

    // Completed-frame count: saturates at 255, cleared on each start from IDLE
    always_comb begin
        fcnt_d      = fcnt_q;
        frame_cnt_d = fcnt_q;
        if (state_q == IDLE && state_d == RUN)
            fcnt_d = 8'd0;
        else if (frame_end && fcnt_q != 8'hFF)
            fcnt_d = fcnt_q + 8'd1;
    end

    // Frame counter registers
    always_ff @(posedge clk_out) begin
        if (rst) begin
            fcnt_q      <= 8'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            fcnt_q      <= fcnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mdll_div_sequencer.sv
// Testbench for mdll_div_sequencer: directed stimulus with a scoreboard queue
// and an independent monitor that checks each output cycle.
module tb_mdll_div_sequencer;
    logic       clk_out = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] N = 4'd2;
    logic [1:0] M = 2'd1;
    logic [3:0] N_counter;
    logic [1:0] M_counter;
    logic       DIV_N, DIV_M, frame_done, cfg_err;
    logic [1:0] Sel;
    logic [7:0] frame_cnt;

    mdll_div_sequencer dut (
        .clk_out   (clk_out),
        .rst       (rst),
        .en        (en),
        .N         (N),
        .M         (M),
        .N_counter (N_counter),
        .M_counter (M_counter),
        .DIV_N     (DIV_N),
        .DIV_M     (DIV_M),
        .Sel       (Sel),
        .frame_done(frame_done),
        .cfg_err   (cfg_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk_out = ~clk_out;

`ifdef FRAME_CNT_EN
    localparam bit FC_ON = 1'b1;
`else
    localparam bit FC_ON = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] nc;
        logic [1:0] mc;
        logic       dn;
        logic       dm;
        logic [1:0] sel;
        logic       fd;
        logic       err;
        logic       fc_chk;
        logic [7:0] fc;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    logic  e_err = 1'b0;

    exp_t  mon_e, mon_g;
    string mon_n;

    function automatic exp_t idle_exp(input logic err, input logic fc_chk);
        exp_t e;
        e        = '0;
        e.sel    = 2'b01;
        e.err    = err;
        e.fc_chk = fc_chk;
        return e;
    endfunction

    // Expected outputs on cycle i (1-based) of an n x m frame
    function automatic exp_t fexp(input int n, input int m, input int i, input logic err, input int fc);
        exp_t e;
        int   nc, mc;
        nc       = (i - 1) % n + 1;
        mc       = (i - 1) / n + 1;
        e        = '0;
        e.nc     = 4'(nc);
        e.mc     = 2'(mc);
        e.dn     = (nc == n);
        e.dm     = (i == n * m);
        e.fd     = (i == n * m);
        e.sel    = (i == 1) ? 2'b00 : ((nc == n) && (mc != m)) ? 2'b10 : 2'b01;
        e.err    = err;
        e.fc_chk = (fc >= 0);
        e.fc     = (fc >= 0) ? 8'(fc) : 8'd0;
        return e;
    endfunction

    task automatic cyc(input logic r, input logic e_in, input logic [3:0] n_in, input logic [1:0] m_in,
                       input exp_t ex, input string nm);
        @(negedge clk_out);
        rst = r;
        en  = e_in;
        N   = n_in;
        M   = m_in;
        if (!FC_ON) begin
            ex.fc_chk = 1'b1;
            ex.fc     = 8'd0;
        end
        sb_q.push_back(ex);
        name_q.push_back(nm);
    endtask

    // One output frame; inputs switch from set a to set b at output cycle chg_at
    task automatic frame(input int n, input int m, input int upto, input int chg_at,
                         input logic en_a, input logic [3:0] na, input logic [1:0] ma,
                         input logic en_b, input logic [3:0] nb, input logic [1:0] mb,
                         input int fc, input string nm);
        for (int i = 1; i <= upto; i++) begin
            if (i < chg_at)
                cyc(1'b0, en_a, na, ma, fexp(n, m, i, e_err, fc), nm);
            else
                cyc(1'b0, en_b, nb, mb, fexp(n, m, i, e_err, fc), nm);
        end
    endtask

    // Monitor: checks each output cycle against the oldest queued expectation
    always @(posedge clk_out) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            mon_n = name_q.pop_front();
            mon_g = '{nc: N_counter, mc: M_counter, dn: DIV_N, dm: DIV_M, sel: Sel, fd: frame_done,
                      err: cfg_err, fc_chk: mon_e.fc_chk, fc: (mon_e.fc_chk ? frame_cnt : mon_e.fc)};
            n_vec++;
            if (mon_g !== mon_e) begin
                n_bad++;
                $display("FAIL %s @%0t: got nc=%0d mc=%0d dn=%b dm=%b sel=%b fd=%b err=%b fc=%0d ; want nc=%0d mc=%0d dn=%b dm=%b sel=%b fd=%b err=%b fc=%0d",
                         mon_n, $time, mon_g.nc, mon_g.mc, mon_g.dn, mon_g.dm, mon_g.sel, mon_g.fd, mon_g.err, mon_g.fc,
                         mon_e.nc, mon_e.mc, mon_e.dn, mon_e.dm, mon_e.sel, mon_e.fd, mon_e.err, mon_e.fc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(1'b1, 1'b0, 4'd2, 2'd1, idle_exp(1'b0, 1'b1), "reset_a");
        cyc(1'b1, 1'b0, 4'd2, 2'd1, idle_exp(1'b0, 1'b1), "reset_b");
        cyc(1'b0, 1'b0, 4'd4, 2'd2, idle_exp(1'b0, 1'b1), "idle_en0");
        // en seen at this edge; counters appear one edge later
        cyc(1'b0, 1'b1, 4'd4, 2'd2, idle_exp(1'b0, 1'b1), "start_latency");
        frame(4, 2, 8, 8, 1'b1, 4'd4, 2'd2, 1'b1, 4'd4, 2'd2, -1, "f4x2_a");
        frame(4, 2, 8, 8, 1'b1, 4'd4, 2'd2, 1'b1, 4'd4, 2'd2, -1, "f4x2_b");
        // N/M change while cycle 3 is showing; frame still completes as 4x2
        frame(4, 2, 8, 4, 1'b1, 4'd4, 2'd2, 1'b1, 4'd3, 2'd3, -1, "f4x2_chg");
        frame(3, 3, 9, 9, 1'b1, 4'd3, 2'd3, 1'b1, 4'd5, 2'd1, -1, "f3x3");
        frame(5, 1, 5, 5, 1'b1, 4'd5, 2'd1, 1'b1, 4'd5, 2'd1, -1, "f5x1_a");
        frame(5, 1, 5, 5, 1'b1, 4'd5, 2'd1, 1'b1, 4'd4, 2'd2, -1, "f5x1_b");
        // en low from cycle 2 onward: frame drains to DIV_M, then IDLE
        frame(4, 2, 8, 3, 1'b1, 4'd4, 2'd2, 1'b0, 4'd4, 2'd2, -1, "drain");
        cyc(1'b0, 1'b0, 4'd4, 2'd2, idle_exp(1'b0, 1'b0), "drain_idle_a");
        cyc(1'b0, 1'b0, 4'd4, 2'd2, idle_exp(1'b0, 1'b0), "drain_idle_b");
        // invalid N from IDLE: error set, stays IDLE; then a valid N restarts
        cyc(1'b0, 1'b1, 4'd1, 2'd2, idle_exp(1'b0, 1'b0), "bad_n_a");
        cyc(1'b0, 1'b1, 4'd1, 2'd2, idle_exp(1'b1, 1'b0), "bad_n_b");
        cyc(1'b0, 1'b1, 4'd6, 2'd1, idle_exp(1'b1, 1'b0), "n6_start");
        e_err = 1'b0;
        frame(6, 1, 6, 6, 1'b1, 4'd6, 2'd1, 1'b1, 4'd6, 2'd1, -1, "f6x1");
        frame(6, 1, 5, 6, 1'b1, 4'd6, 2'd1, 1'b1, 4'd6, 2'd1, -1, "f6x1_pre_rst");
        // rst while cycle 5 is showing: reset values next, no frame_done
        cyc(1'b1, 1'b1, 4'd6, 2'd1, idle_exp(1'b0, 1'b1), "rst_mid");
        cyc(1'b0, 1'b0, 4'd6, 2'd1, idle_exp(1'b0, 1'b1), "post_rst_a");
        cyc(1'b0, 1'b0, 4'd6, 2'd1, idle_exp(1'b0, 1'b1), "post_rst_b");
        // invalid M presented at a frame boundary
        cyc(1'b0, 1'b1, 4'd2, 2'd1, idle_exp(1'b0, 1'b1), "start_2x1");
        frame(2, 1, 2, 2, 1'b1, 4'd2, 2'd1, 1'b1, 4'd2, 2'd0, -1, "f2x1_bad_m");
        cyc(1'b0, 1'b0, 4'd2, 2'd1, idle_exp(1'b1, 1'b0), "bad_m_idle");
        cyc(1'b0, 1'b0, 4'd2, 2'd1, idle_exp(1'b1, 1'b0), "err_sticky");
        // long 2x1 run for the frame counter
        cyc(1'b0, 1'b1, 4'd2, 2'd1, idle_exp(1'b1, 1'b0), "fc_start");
        e_err = 1'b0;
        for (int j = 1; j <= 300; j++)
            frame(2, 1, 2, 2, 1'b1, 4'd2, 2'd1, 1'b1, 4'd2, 2'd1, (j - 1 > 255) ? 255 : j - 1, "fc_run");
        @(posedge clk_out);
        #3;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
